// File: rtl/protocol_pkg.sv
// Shared I2S protocol definitions: default slot length, channel encoding
// and the receiver state encoding.
package protocol_pkg;

   localparam int I2S_SLOT_BITS = 24;

   typedef enum logic {
      LEFT  = 1'b0,
      RIGHT = 1'b1
   } channel_t;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      RUN
   } i2s_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level, plus a history flop that
// yields single-clk rise and fall pulses in the clk domain.
module sync_edge_detect (
   input  logic clk,
   input  logic rstn,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync;
   logic hist;

   // NOTE: non-blocking assignments so each stage takes the previous stage's old value.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta <= 1'b0;
         sync <= 1'b0;
         hist <= 1'b0;
      end else begin
         meta <= async_in;
         sync <= meta;
         hist <= sync;
      end
   end

   assign sync_out = sync;
   assign rise     = sync & ~hist;
   assign fall     = ~sync & hist;

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S receiver: oversamples sclk/lrclk/sd in the clk domain and emits
// left/right sample pairs. Define I2S_RX_FRAME_CHECK_EN for slot-length checking.
module i2s_receiver
   import protocol_pkg::*;
#(
   parameter int WIDTH     = 24,
   parameter int SLOT_BITS = I2S_SLOT_BITS
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enable,
   input  logic             sclk,
   input  logic             lrclk,
   input  logic             sd,
   output logic [WIDTH-1:0] left_data,
   output logic [WIDTH-1:0] right_data,
   output logic             valid,
   output logic             frame_error
);

   localparam int CNT_W = $clog2(SLOT_BITS + 2);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic             sclk_rise;
   logic             sclk_sync_unused;
   logic             sclk_fall_unused;
   logic             lr_meta, lr_s;
   logic             sd_meta, sd_s;

   i2s_state_t       state, state_next;
   logic             in_sync, in_run;

   channel_t         lr_prev;
   logic             lr_seen;
   logic             lr_change;
   logic [WIDTH-1:0] word, word_next;
   logic [IDX_W-1:0] bit_idx;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_inc;
   logic [WIDTH-1:0] left_stage;
   logic             left_pending;
   logic             slot_bad;

   sync_edge_detect u_sclk_sync (
      .clk      (clk),
      .rstn     (rstn),
      .async_in (sclk),
      .sync_out (sclk_sync_unused),
      .rise     (sclk_rise),
      .fall     (sclk_fall_unused)
   );

   // lrclk and sd share sclk's two-stage depth so all three stay aligned.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lr_meta <= 1'b0;
         lr_s    <= 1'b0;
         sd_meta <= 1'b0;
         sd_s    <= 1'b0;
      end else begin
         lr_meta <= lrclk;
         lr_s    <= lr_meta;
         sd_meta <= sd;
         sd_s    <= sd_meta;
      end
   end

   assign lr_change = sclk_rise && lr_seen && (channel_t'(lr_s) != lr_prev);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (!enable) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    state_next = SYNC;
            SYNC:    if (lr_change) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      in_sync = (state == SYNC) && enable;
      in_run  = (state == RUN) && enable;
   end

   // NOTE: defaults first so every path assigns and no latch is inferred.
   always_comb begin
      word_next = word;
      bit_idx   = IDX_W'(WIDTH - 1 - int'(bit_cnt));
      if (int'(bit_cnt) < WIDTH) word_next[bit_idx] = sd_s;
   end

   assign bit_cnt_inc = (int'(bit_cnt) < SLOT_BITS + 1) ? bit_cnt + CNT_W'(1) : bit_cnt;

`ifdef I2S_RX_FRAME_CHECK_EN
   assign slot_bad = (int'(bit_cnt) + 1) != SLOT_BITS;
`else
   assign slot_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lr_prev      <= LEFT;
         lr_seen      <= 1'b0;
         word         <= '0;
         bit_cnt      <= '0;
         left_stage   <= '0;
         left_pending <= 1'b0;
         left_data    <= '0;
         right_data   <= '0;
         valid        <= 1'b0;
         frame_error  <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (sclk_rise) begin
            lr_prev <= channel_t'(lr_s);
            lr_seen <= 1'b1;
         end

         if (!enable) begin
            word         <= '0;
            bit_cnt      <= '0;
            left_pending <= 1'b0;
            frame_error  <= 1'b0;
         end else if (in_sync && lr_change) begin
            word    <= '0;
            bit_cnt <= '0;
         end else if (in_run && sclk_rise) begin
            if (!lr_change) begin
               word    <= word_next;
               bit_cnt <= bit_cnt_inc;
            end else begin
               // Slot boundary: word_next already holds the previous slot's LSB.
               word    <= '0;
               bit_cnt <= '0;
               if (slot_bad) begin
                  left_pending <= 1'b0;
                  frame_error  <= 1'b1;
               end else if (lr_prev == LEFT) begin
                  left_stage   <= word_next;
                  left_pending <= 1'b1;
               end else if (left_pending) begin
                  left_data    <= left_stage;
                  right_data   <= word_next;
                  valid        <= 1'b1;
                  left_pending <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: drives a Philips I2S stream at clk/8 and
// checks committed sample pairs, reset, enable gating and short slots.
module tb_i2s_receiver;

   localparam int WIDTH     = 24;
   localparam int HALF_CLKS = 4;
   localparam int LR_CLKS   = 2 * 24 * 2 * HALF_CLKS;

   logic             clk = 1'b0;
   logic             rstn;
   logic             enable;
   logic             sclk;
   logic             lrclk;
   logic             sd;
   logic [WIDTH-1:0] left_data;
   logic [WIDTH-1:0] right_data;
   logic             valid;
   logic             frame_error;

   int   checks         = 0;
   int   failures       = 0;
   int   valid_cnt      = 0;
   int   double_cnt     = 0;
   int   cyc            = 0;
   int   last_valid_cyc = 0;
   logic prev_valid     = 1'b0;
   logic prev_bit       = 1'b0;
   int   base;
   int   en_cyc;
   logic [23:0] exp_l, exp_r;

   always #5 clk = ~clk;

   i2s_receiver dut (
      .clk         (clk),
      .rstn        (rstn),
      .enable      (enable),
      .sclk        (sclk),
      .lrclk       (lrclk),
      .sd          (sd),
      .left_data   (left_data),
      .right_data  (right_data),
      .valid       (valid),
      .frame_error (frame_error)
   );

   always @(negedge clk) begin
      cyc++;
      if (valid === 1'b1) begin
         valid_cnt++;
         last_valid_cyc = cyc;
         if (prev_valid) double_cnt++;
      end
      prev_valid = valid;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic sclk_bit(input logic lr, input logic b);
      lrclk = lr;
      sd    = b;
      repeat (HALF_CLKS) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF_CLKS) @(negedge clk);
      sclk = 1'b0;
   endtask

   // One-bit Philips delay: each period carries the bit queued by the previous one.
   task automatic send_slot(input logic ch, input logic [23:0] word, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         sclk_bit(ch, prev_bit);
         prev_bit = word[nbits-1-i];
      end
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int nbits);
      send_slot(1'b0, l, nbits);
      send_slot(1'b1, r, nbits);
   endtask

   task automatic settle();
      repeat (20) @(negedge clk);
   endtask

   initial begin
      rstn   = 1'b0;
      enable = 1'b0;
      sclk   = 1'b0;
      lrclk  = 1'b0;
      sd     = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_left", left_data, 0);
      check("rst_right", right_data, 0);
      check("rst_valid", valid, 0);
      check("rst_ferr", frame_error, 0);
      rstn = 1'b1;
      repeat (3) @(negedge clk);

      // Loopback pattern: first frame only syncs, so 3 frames give 2 pairs.
      base   = valid_cnt;
      enable = 1'b1;
      repeat (3) send_frame(24'h123456, 24'hABCDEF, 24);
      send_slot(1'b0, 24'h000000, 24);
      settle();
      check("a_count", valid_cnt - base, 2);
      check("a_left", left_data, 24'h123456);
      check("a_right", right_data, 24'hABCDEF);
      check("a_ferr", frame_error, 0);
      enable = 1'b0;
      settle();

      base   = valid_cnt;
      enable = 1'b1;
      repeat (2) send_frame(24'h7FFFFF, 24'h800000, 24);
      send_slot(1'b0, 24'h000000, 24);
      settle();
      check("b_count", valid_cnt - base, 1);
      check("b_left", left_data, 24'h7FFFFF);
      check("b_right", right_data, 24'h800000);
      enable = 1'b0;
      settle();

      // Stream starts mid-left-slot after a reset.
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      base   = valid_cnt;
      enable = 1'b1;
      send_slot(1'b0, 24'h0003FF, 10);
      send_slot(1'b1, 24'h111111, 24);
      send_frame(24'h222222, 24'h333333, 24);
      send_slot(1'b0, 24'h000000, 24);
      settle();
      check("c_count", valid_cnt - base, 1);
      check("c_left", left_data, 24'h222222);
      check("c_right", right_data, 24'h333333);
      enable = 1'b0;
      settle();

      // Reset pulse in the middle of the first right slot.
      base   = valid_cnt;
      enable = 1'b1;
      fork
         begin
            repeat (4) send_frame(24'h0A0B0C, 24'hF0E0D0, 24);
            send_slot(1'b0, 24'h000000, 24);
         end
         begin
            repeat (30 * 2 * HALF_CLKS) @(negedge clk);
            rstn = 1'b0;
            #1;
            check("d_rst_left", left_data, 0);
            check("d_rst_right", right_data, 0);
            check("d_rst_valid", valid, 0);
            repeat (3) @(negedge clk);
            rstn = 1'b1;
            base = valid_cnt;
         end
      join
      settle();
      exp_l = 24'h0A0B0C;
      exp_r = 24'hF0E0D0;
      check("d_count", valid_cnt - base, 3);
      check("d_left", left_data, exp_l);
      check("d_right", right_data, exp_r);
      enable = 1'b0;
      settle();

      // 20-bit slots: zero-filled LSBs, or a frame error when checking is built in.
      base   = valid_cnt;
      enable = 1'b1;
      repeat (2) send_frame(24'h0FFFFF, 24'h0ABCDE, 20);
      send_slot(1'b0, 24'h000000, 20);
      settle();
`ifdef I2S_RX_FRAME_CHECK_EN
      check("e_count", valid_cnt - base, 0);
      check("e_ferr", frame_error, 1);
`else
      exp_l = 24'hFFFFF0;
      exp_r = 24'hABCDE0;
      check("e_count", valid_cnt - base, 1);
      check("e_ferr", frame_error, 0);
`endif
      check("e_left", left_data, exp_l);
      check("e_right", right_data, exp_r);
      enable = 1'b0;
      settle();

      // Enable dropped for three frames while the stream keeps running.
      base   = valid_cnt;
      enable = 1'b1;
      repeat (2) send_frame(24'h654321, 24'h0FEDCB, 24);
      enable = 1'b0;
      repeat (3) send_frame(24'h111111, 24'h222222, 24);
      send_slot(1'b0, 24'h111111, 24);
      check("f_off_count", valid_cnt - base, 0);
      check("f_off_left", left_data, exp_l);
      check("f_off_right", right_data, exp_r);
      check("f_off_ferr", frame_error, 0);
      en_cyc = cyc;
      enable = 1'b1;
      send_slot(1'b1, 24'h222222, 24);
      send_frame(24'h333333, 24'h444444, 24);
      send_slot(1'b0, 24'h000000, 24);
      settle();
      check("f_count", valid_cnt - base, 1);
      check("f_left", left_data, 24'h333333);
      check("f_right", right_data, 24'h444444);
      check("f_latency_ok", 32'((last_valid_cyc - en_cyc) <= 2 * LR_CLKS), 1);

      check("no_back_to_back", double_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
